// File: rtl/vend_pkg.sv
// Shared constants for the vending credit controller: coin values and FSM state encoding.
package vend_pkg;

    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;
    localparam int COIN_20 = 20;
    localparam int COIN_W  = 5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_CHANGE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_COLLECT  = ST_COLLECT,
        S_DISPENSE = ST_DISPENSE,
        S_CHANGE   = ST_CHANGE
    } state_e;

endpackage

// File: rtl/vend_coin_encoder.sv
// Maps the three coin pulses to {valid, value}; when several are high the largest coin wins.
module vend_coin_encoder
    import vend_pkg::*;
(
    input  logic              coin5_i,
    input  logic              coin10_i,
    input  logic              coin20_i,
    output logic              valid_o,
    output logic [COIN_W-1:0] value_o
);

    always_comb begin
        valid_o = coin5_i | coin10_i | coin20_i;
        value_o = '0;
        if (coin20_i) begin
            value_o = COIN_W'(COIN_20);
        end else if (coin10_i) begin
            value_o = COIN_W'(COIN_10);
        end else if (coin5_i) begin
            value_o = COIN_W'(COIN_5);
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin credit accumulator and dispense/change FSM.
// Define VEND_CHANGE_RETURN_EN to return the remainder as 5-unit change pulses instead of carrying it over.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 40,
    parameter int CREDIT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin5_i,
    input  logic                coin10_i,
    input  logic                coin20_i,
    input  logic                dispense_ack_i,
    output logic                dispense_o,
    output logic                change5_o,
    output logic                coin_reject_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy_o
);

    localparam int SUM_W = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic              coin_vld;
    logic [COIN_W-1:0] coin_val;
    logic [SUM_W-1:0]  sum;
    logic [CREDIT_W-1:0] rem;

    vend_coin_encoder u_enc (
        .coin5_i  (coin5_i),
        .coin10_i (coin10_i),
        .coin20_i (coin20_i),
        .valid_o  (coin_vld),
        .value_o  (coin_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        // One extra bit so a coin on top of high credit cannot wrap before the ceiling check.
        sum      = {1'b0, credit_q} + SUM_W'(coin_val);
        rem      = credit_q - CREDIT_W'(PRICE);

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (coin_vld) begin
                    if (sum > SUM_W'(MAX_CREDIT)) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= SUM_W'(PRICE)) ? S_DISPENSE : S_COLLECT;
                    end
                end
            end
            S_DISPENSE: begin
                reject_d = coin_vld;
                if (dispense_ack_i) begin
                    credit_d = rem;
`ifdef VEND_CHANGE_RETURN_EN
                    state_d  = (rem != '0) ? S_CHANGE : S_IDLE;
`else
                    if (rem >= CREDIT_W'(PRICE)) begin
                        state_d = S_DISPENSE;
                    end else if (rem != '0) begin
                        state_d = S_COLLECT;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end
            end
`ifdef VEND_CHANGE_RETURN_EN
            S_CHANGE: begin
                reject_d = coin_vld;
                credit_d = credit_q - CREDIT_W'(COIN_5);
                if (credit_q <= CREDIT_W'(COIN_5)) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dispense_o    = (state_q == S_DISPENSE);
    assign coin_reject_o = reject_q;
    assign credit_o      = credit_q;
`ifdef VEND_CHANGE_RETURN_EN
    assign change5_o     = (state_q == S_CHANGE);
    assign busy_o        = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
`else
    assign change5_o     = 1'b0;
    assign busy_o        = (state_q == S_DISPENSE);
`endif

endmodule
